ql_episode_ctrl: RTL and testbench

//  Sequences Q-learning episodes around the policy generator (PG) and the Q-table.
//  Per step: fetches the state's Q-values, presents them to PG, captures action and next state,

---
 rtl/ql_pkg.sv | 16 +
 rtl/ql_episode_ctrl_if.sv | 32 +++
 rtl/ql_bounded_counter.sv | 27 ++
 rtl/ql_episode_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ql_episode_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ql_pkg.sv
// Shared widths and the controller state encoding for the Q-learning
// episode controller.
//   STATE_W : state index width (64 states)
//   ACT_W   : PG action code width
//   QV_W    : packed Q-value vector width (4 actions x 16b)
//   EP_W    : episode counter width
package ql_pkg;
  localparam int STATE_W = 6;
  localparam int ACT_W   = 4;
  localparam int QV_W    = 64;
  localparam int EP_W    = 16;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SELECT, UPDATE, ADVANCE, FINISH
  } ctrl_state_t;
endpackage

// File: rtl/ql_episode_ctrl_if.sv
// Datapath bus of the episode controller: Q-table read port, policy
// generator (PG) hookup and the (s,a,s') hand-off to the Q-updater.
//   master : the controller
//   slave  : Q-table / PG / Q-updater side
interface ql_episode_ctrl_if;
  import ql_pkg::*;

  logic               q_rd_en;
  logic [STATE_W-1:0] q_rd_addr;
  logic [QV_W-1:0]    q_rd_data;
  logic [QV_W-1:0]    pg_q_values;
  logic [STATE_W-1:0] pg_state;
  logic [STATE_W-1:0] pg_st_next;
  logic [ACT_W-1:0]   pg_at;
  logic               upd_valid;
  logic               upd_ready;
  logic [STATE_W-1:0] upd_state;
  logic [ACT_W-1:0]   upd_action;
  logic [STATE_W-1:0] upd_next_state;

  modport master (
    output q_rd_en, q_rd_addr, pg_q_values, pg_state,
           upd_valid, upd_state, upd_action, upd_next_state,
    input  q_rd_data, pg_st_next, pg_at, upd_ready
  );

  modport slave (
    input  q_rd_en, q_rd_addr, pg_q_values, pg_state,
           upd_valid, upd_state, upd_action, upd_next_state,
    output q_rd_data, pg_st_next, pg_at, upd_ready
  );
endinterface

// File: rtl/ql_bounded_counter.sv
// Clearable up-counter with a "next increment reaches limit" flag.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : increment by one
//   limit      : bound compared against count+1
//   count      : current value
//   hit        : count+1 == limit
module ql_bounded_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         hit
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + W'(1);
  end

  // Extra bit so count = all-ones never aliases onto a zero limit.
  assign hit = ({1'b0, count} + {{W{1'b0}}, 1'b1}) == {1'b0, limit};
endmodule

// File: rtl/ql_episode_ctrl.sv
// Q-learning episode sequencer. Per step: read the state's Q-values, present
// them to PG, capture PG's next state, hand (s,a,s') to the Q-updater, then
// advance. An episode ends on GOAL_STATE or after MAX_STEPS steps; the run ends
// after num_episodes episodes (done pulse) or on abort (no done).
//   clk, rst_n      : clock, async active-low reset
//   start           : run request, accepted only in IDLE
//   num_episodes    : episodes per run, sampled on start
//   abort           : return to IDLE (deferred to the handshake while in UPDATE)
//   bus             : ql_episode_ctrl_if.master (Q-table, PG, Q-updater)
//   busy, done      : run in progress / run completed pulse
//   ep_count        : completed episodes this run
//   step_count      : steps taken in the current episode
// Optional build macro EPISODE_STATS_EN adds last_ep_steps and goal_hits.
module ql_episode_ctrl
  import ql_pkg::*;
#(
  parameter int START_STATE = 0,
  parameter int GOAL_STATE  = 35,
  parameter int MAX_STEPS   = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [EP_W-1:0]   num_episodes,
  input  logic              abort,
  ql_episode_ctrl_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [EP_W-1:0]   ep_count,
  output logic [7:0]        step_count
`ifdef EPISODE_STATS_EN
  ,
  output logic [7:0]        last_ep_steps,
  output logic [EP_W-1:0]   goal_hits
`endif
);
  localparam logic [STATE_W-1:0] START_S = STATE_W'(START_STATE);
  localparam logic [STATE_W-1:0] GOAL_S  = STATE_W'(GOAL_STATE);
  localparam logic [7:0]         MAX_S   = 8'(MAX_STEPS);

  ctrl_state_t        st;
  logic [STATE_W-1:0] cur_state, nxt_reg, adv_state;
  logic [EP_W-1:0]    num_ep_reg;
  logic               abort_pend;
  logic               accept, run_clr, adv, ep_end, step_hit, ep_hit;

  assign accept    = (st == IDLE) && start;
  assign run_clr   = accept && (num_episodes != '0);
  assign adv       = (st == ADVANCE) && !abort;
  // Goal and step limit in the same step still count as a single episode end.
  assign ep_end    = (nxt_reg == GOAL_S) || step_hit;
  assign adv_state = ep_end ? START_S : nxt_reg;

  ql_bounded_counter #(.W(8)) u_step (
    .clk, .rst_n,
    .clr  (run_clr || (adv && ep_end)),
    .inc  (adv),
    .limit(MAX_S),
    .count(step_count),
    .hit  (step_hit)
  );

  ql_bounded_counter #(.W(EP_W)) u_ep (
    .clk, .rst_n,
    .clr  (run_clr),
    .inc  (adv && ep_end),
    .limit(num_ep_reg),
    .count(ep_count),
    .hit  (ep_hit)
  );

  assign bus.pg_state       = cur_state;
  assign bus.upd_state      = cur_state;
  assign bus.upd_next_state = nxt_reg;
  // PG holds pg_at while its inputs are held, so it is stable through UPDATE.
  assign bus.upd_action     = (st == UPDATE) ? bus.pg_at : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= IDLE;
      cur_state       <= START_S;
      nxt_reg         <= '0;
      num_ep_reg      <= '0;
      abort_pend      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      bus.q_rd_en     <= 1'b0;
      bus.q_rd_addr   <= '0;
      bus.pg_q_values <= '0;
      bus.upd_valid   <= 1'b0;
    end else begin
      bus.q_rd_en <= 1'b0;
      done        <= 1'b0;
      if (abort && st != IDLE && st != UPDATE) begin
        st            <= IDLE;
        busy          <= 1'b0;
        cur_state     <= START_S;
        bus.upd_valid <= 1'b0;
        abort_pend    <= 1'b0;
      end else begin
        case (st)
          IDLE: if (start) begin
            busy       <= 1'b1;
            num_ep_reg <= num_episodes;
            if (num_episodes == '0) begin
              st   <= FINISH;
              done <= 1'b1;
            end else begin
              st            <= FETCH;
              bus.q_rd_en   <= 1'b1;
              bus.q_rd_addr <= cur_state;
            end
          end
          FETCH: st <= LOAD;
          LOAD: begin
            bus.pg_q_values <= bus.q_rd_data;
            st              <= SELECT;
          end
          SELECT: begin
            nxt_reg       <= bus.pg_st_next;
            bus.upd_valid <= 1'b1;
            st            <= UPDATE;
          end
          UPDATE: begin
            if (bus.upd_ready) begin
              bus.upd_valid <= 1'b0;
              if (abort || abort_pend) begin
                st         <= IDLE;
                busy       <= 1'b0;
                cur_state  <= START_S;
                abort_pend <= 1'b0;
              end else begin
                st <= ADVANCE;
              end
            end else if (abort) begin
              abort_pend <= 1'b1;
            end
          end
          ADVANCE: begin
            cur_state <= adv_state;
            if (ep_end && ep_hit) begin
              st   <= FINISH;
              done <= 1'b1;
            end else begin
              st            <= FETCH;
              bus.q_rd_en   <= 1'b1;
              bus.q_rd_addr <= adv_state;
            end
          end
          FINISH: begin
            st   <= IDLE;
            busy <= 1'b0;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

`ifdef EPISODE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ep_steps <= '0;
      goal_hits     <= '0;
    end else begin
      if (accept)
        goal_hits <= '0;
      else if (adv && nxt_reg == GOAL_S)
        goal_hits <= goal_hits + EP_W'(1);
      if (adv && ep_end)
        last_ep_steps <= step_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ql_episode_ctrl.sv
// Self-checking bench for ql_episode_ctrl. The Q-table and PG are modelled by
// random tables; expected (s,a,s') streams come from an episode-level model.
module tb_ql_episode_ctrl;
  import ql_pkg::*;

  localparam int GOAL = 35;
  localparam int MAXS = 63;

  typedef struct packed {
    logic [STATE_W-1:0] s;
    logic [ACT_W-1:0]   a;
    logic [STATE_W-1:0] ns;
  } tup_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [EP_W-1:0] num_episodes = '0;
  logic            busy, done;
  logic [EP_W-1:0] ep_count;
  logic [7:0]      step_count;
`ifdef EPISODE_STATS_EN
  logic [7:0]      last_ep_steps;
  logic [EP_W-1:0] goal_hits;
`endif

  ql_episode_ctrl_if bus();

  logic [QV_W-1:0]    qmem [64];
  logic [STATE_W-1:0] nt   [64];
  tup_t got_q[$];
  tup_t exp_q[$];
  int   fetch_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   rd_cnt = 0;
  int   total = 0;
  int   bad = 0;

  ql_episode_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_episodes (num_episodes),
    .abort        (abort),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .ep_count     (ep_count),
    .step_count   (step_count)
`ifdef EPISODE_STATS_EN
    ,
    .last_ep_steps(last_ep_steps),
    .goal_hits    (goal_hits)
`endif
  );

  always #5 clk = ~clk;

  // PG: combinational next state from a table, registered action.
  assign bus.pg_st_next = nt[bus.pg_state];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.pg_at <= '0;
    else        bus.pg_at <= bus.pg_q_values[ACT_W-1:0] ^ bus.pg_state[ACT_W-1:0];
  end

  // Q-table: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk)
    bus.q_rd_data <= bus.q_rd_en ? qmem[bus.q_rd_addr] : {$urandom, $urandom};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.q_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      fetch_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (bus.upd_valid && bus.upd_ready)
      got_q.push_back({bus.upd_state, bus.upd_action, bus.upd_next_state});
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_qmem();
    for (int i = 0; i < 64; i++) qmem[i] = {$urandom, $urandom};
  endtask

  function automatic logic [STATE_W-1:0] non_goal();
    int r;
    r = $urandom_range(0, 62);
    if (r >= GOAL) r++;
    return STATE_W'(r);
  endfunction

  task automatic rand_table(input int goal_pct);
    for (int i = 0; i < 64; i++)
      nt[i] = ($urandom_range(0, 99) < goal_pct) ? STATE_W'(GOAL) : non_goal();
  endtask

  // Expected tuple stream of a run of n episodes, from the episode rules.
  task automatic model_run(input int n);
    logic [STATE_W-1:0] s;
    int  k;
    bit  fin;
    tup_t t;
    exp_q.delete();
    for (int e = 0; e < n; e++) begin
      s = '0; k = 0; fin = 1'b0;
      while (!fin) begin
        t.s  = s;
        t.a  = qmem[s][ACT_W-1:0] ^ s[ACT_W-1:0];
        t.ns = nt[s];
        exp_q.push_back(t);
        k++;
        if (nt[s] == STATE_W'(GOAL) || k == MAXS) fin = 1'b1;
        else s = nt[s];
      end
    end
  endtask

  function automatic int tup_mism(input int base);
    int m;
    m = 0;
    if (got_q.size() - base != exp_q.size()) return 1000;
    foreach (exp_q[i]) if (got_q[base + i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic pulse_start(input int n);
    @(negedge clk);
    num_episodes = EP_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_got(input int target, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (got_q.size() >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.upd_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic chain_table();
    for (int i = 0; i < 64; i++) nt[i] = non_goal();
    nt[0]  = 6'd12;
    nt[12] = 6'(GOAL);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, bus.q_rd_en, bus.upd_valid} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, bus.q_rd_en, bus.upd_valid});
    end
    total++;
    if (ep_count !== '0 || step_count !== '0) begin
      bad++; $display("FAIL reset_counts: ep=%0d step=%0d want 0/0", ep_count, step_count);
    end
    total++;
    if (bus.pg_state !== '0 || bus.q_rd_addr !== '0) begin
      bad++; $display("FAIL reset_state: pg_state=%0d addr=%0d want 0", bus.pg_state, bus.q_rd_addr);
    end
    total++;
    if (bus.pg_q_values !== '0 || bus.upd_action !== '0) begin
      bad++; $display("FAIL reset_pg: qv=%h act=%0d want 0", bus.pg_q_values, bus.upd_action);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_goal();
    int b_got, b_f, b_d, b_rd, m;
    bit ok;
    fill_qmem(); chain_table(); model_run(1);
    b_got = got_q.size(); b_f = fetch_q.size(); b_d = done_q.size(); b_rd = rd_cnt;
    pulse_start(1);
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL goal_timeout: busy=%b want 0", busy); end
    m = tup_mism(b_got);
    total++;
    if (m != 0) begin bad++; $display("FAIL goal_tuples: mismatches=%0d got=%0d want=%0d", m, got_q.size() - b_got, exp_q.size()); end
    total++;
    if (done_q.size() - b_d != 1 || fetch_q.size() - b_f < 1 || done_q[b_d] - fetch_q[b_f] != 10) begin
      bad++; $display("FAIL goal_done_latency: done pulses=%0d want 1, latency 10", done_q.size() - b_d);
    end
    total++;
    if (rd_cnt - b_rd != 2 || ep_count !== 16'd1) begin
      bad++; $display("FAIL goal_counts: reads=%0d ep=%0d want 2/1", rd_cnt - b_rd, ep_count);
    end
  endtask

  task automatic test_step_limit();
    int b_got, b_d, m, step_max;
    bit ok;
    fill_qmem();
    for (int i = 0; i < 64; i++) nt[i] = non_goal();
    model_run(1);
    b_got = got_q.size(); b_d = done_q.size();
    pulse_start(1);
    ok = 1'b0; step_max = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (int'(step_count) > step_max) step_max = int'(step_count);
      if (!busy) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL limit_timeout: busy=%b want 0", busy); end
    m = tup_mism(b_got);
    total++;
    if (m != 0) begin bad++; $display("FAIL limit_tuples: mismatches=%0d got=%0d want=%0d", m, got_q.size() - b_got, exp_q.size()); end
    total++;
    if (step_max != MAXS - 1 || step_count !== 8'd0) begin
      bad++; $display("FAIL limit_steps: max=%0d final=%0d want 62/0", step_max, step_count);
    end
    total++;
    if (ep_count !== 16'd1 || bus.pg_state !== '0 || done_q.size() - b_d != 1) begin
      bad++; $display("FAIL limit_end: ep=%0d state=%0d done=%0d want 1/0/1", ep_count, bus.pg_state, done_q.size() - b_d);
    end
  endtask

  task automatic test_stall();
    int b_got, b_f, b_rd, m;
    bit ok, stable;
    tup_t snap;
    fill_qmem(); chain_table(); model_run(1);
    b_got = got_q.size(); b_f = fetch_q.size(); b_rd = rd_cnt;
    bus.upd_ready = 1'b0;
    pulse_start(1);
    wait_valid(20, ok);
    snap = {bus.upd_state, bus.upd_action, bus.upd_next_state};
    stable = ok;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!bus.upd_valid || {bus.upd_state, bus.upd_action, bus.upd_next_state} !== snap) stable = 1'b0;
    end
    bus.upd_ready = 1'b1;
    wait_idle(200, ok);
    total++;
    if (!stable || !ok) begin bad++; $display("FAIL stall_hold: stable=%b idle=%b want 1/1", stable, ok); end
    m = tup_mism(b_got);
    total++;
    if (m != 0) begin bad++; $display("FAIL stall_tuples: mismatches=%0d want 0", m); end
    total++;
    if (fetch_q.size() - b_f != 2 || fetch_q[b_f + 1] - fetch_q[b_f] != 9) begin
      bad++; $display("FAIL stall_latency: fetches=%0d want 2 with step latency 9", fetch_q.size() - b_f);
    end
    total++;
    if (rd_cnt - b_rd != 2) begin bad++; $display("FAIL stall_reads: got %0d want 2", rd_cnt - b_rd); end
  endtask

  task automatic test_abort();
    int b_got, b_d, b_rd, m;
    bit ok, held;
    // Abort inside the second UPDATE: held until the handshake.
    fill_qmem(); chain_table(); model_run(1);
    b_got = got_q.size(); b_d = done_q.size();
    pulse_start(1);
    wait_got(b_got + 1, 50, ok);
    bus.upd_ready = 1'b0;
    wait_valid(20, ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    held = busy && bus.upd_valid;
    @(negedge clk);
    held = held && busy && bus.upd_valid;
    bus.upd_ready = 1'b1;
    @(negedge clk);
    total++;
    if (!ok || !held || busy !== 1'b0) begin
      bad++; $display("FAIL abort_update: valid_seen=%b held=%b busy=%b want 1/1/0", ok, held, busy);
    end
    m = tup_mism(b_got);
    total++;
    if (m != 0) begin bad++; $display("FAIL abort_update_tuples: mismatches=%0d want 0", m); end
    total++;
    if (bus.pg_state !== '0 || step_count !== 8'd1 || ep_count !== '0 || done_q.size() != b_d) begin
      bad++; $display("FAIL abort_update_regs: state=%0d step=%0d ep=%0d done=%0d want 0/1/0/0",
                      bus.pg_state, step_count, ep_count, done_q.size() - b_d);
    end
    // Abort in LOAD: IDLE on the next cycle.
    b_got = got_q.size(); b_rd = rd_cnt;
    pulse_start(1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_load_busy: got %b want 0", busy); end
    repeat (8) @(negedge clk);
    total++;
    if (got_q.size() != b_got || rd_cnt - b_rd != 1 || done_q.size() != b_d) begin
      bad++; $display("FAIL abort_load_quiet: tuples=%0d reads=%0d done=%0d want 0/1/0",
                      got_q.size() - b_got, rd_cnt - b_rd, done_q.size() - b_d);
    end
  endtask

  task automatic test_zero_and_busy();
    int b_got, b_d, b_rd, m;
    bit ok, dn;
    b_d = done_q.size(); b_rd = rd_cnt;
    pulse_start(0);
    dn = done;
    wait_idle(10, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || !dn || done_q.size() - b_d != 1 || rd_cnt != b_rd) begin
      bad++; $display("FAIL zero_episodes: idle=%b done_now=%b pulses=%0d reads=%0d want 1/1/1/0",
                      ok, dn, done_q.size() - b_d, rd_cnt - b_rd);
    end
    fill_qmem(); chain_table(); model_run(1);
    b_got = got_q.size(); b_d = done_q.size();
    pulse_start(1);
    repeat (2) @(negedge clk);
    start = 1'b1; num_episodes = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle(200, ok);
    repeat (5) @(negedge clk);
    m = tup_mism(b_got);
    total++;
    if (!ok || m != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_start_tuples: idle=%b mismatches=%0d busy=%b want 1/0/0", ok, m, busy);
    end
    total++;
    if (done_q.size() - b_d != 1 || ep_count !== 16'd1) begin
      bad++; $display("FAIL busy_start_end: done=%0d ep=%0d want 1/1", done_q.size() - b_d, ep_count);
    end
  endtask

  task automatic test_midreset();
    bit ok;
    fill_qmem(); chain_table();
    pulse_start(1);
    wait_valid(20, ok);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (!ok || bus.upd_valid !== 1'b0 || busy !== 1'b0 || bus.pg_q_values !== '0 || bus.pg_state !== '0) begin
      bad++; $display("FAIL midreset: seen=%b valid=%b busy=%b qv=%h want 1/0/0/0",
                      ok, bus.upd_valid, busy, bus.pg_q_values);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int b_got, b_d, m, n;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      fill_qmem(); rand_table(20);
      n = $urandom_range(1, 3);
      model_run(n);
      b_got = got_q.size(); b_d = done_q.size();
      pulse_start(n);
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
        @(negedge clk);
        bus.upd_ready = 1'($urandom_range(0, 1));
        if (!busy) begin ok = 1'b1; break; end
      end
      bus.upd_ready = 1'b1;
      m = tup_mism(b_got);
      total++;
      if (!ok || m != 0) begin
        bad++; $display("FAIL random_tuples[%0d]: idle=%b mismatches=%0d got=%0d want=%0d",
                        it, ok, m, got_q.size() - b_got, exp_q.size());
      end
      total++;
      if (ep_count !== EP_W'(n) || step_count !== 8'd0 || done_q.size() - b_d != 1) begin
        bad++; $display("FAIL random_end[%0d]: ep=%0d step=%0d done=%0d want %0d/0/1",
                        it, ep_count, step_count, done_q.size() - b_d, n);
      end
    end
  endtask

`ifdef EPISODE_STATS_EN
  task automatic test_stats();
    int b_got, b_d;
    bit ok1, ok2;
    logic [EP_W-1:0] gh0;
    fill_qmem();
    for (int i = 0; i < 64; i++) nt[i] = non_goal();
    nt[0] = 6'd5;
    nt[5] = 6'(GOAL);
    b_got = got_q.size(); b_d = done_q.size();
    pulse_start(3);
    gh0 = goal_hits;
    wait_got(b_got + 4, 200, ok1);
    nt[0] = 6'd7;
    nt[5] = 6'd9;
    wait_idle(3000, ok2);
    total++;
    if (!ok1 || !ok2 || gh0 !== '0 || goal_hits !== 16'd2) begin
      bad++; $display("FAIL stats_goal_hits: cleared=%0d final=%0d want 0/2", gh0, goal_hits);
    end
    total++;
    if (last_ep_steps !== 8'd63 || ep_count !== 16'd3 || got_q.size() - b_got != 67 || done_q.size() - b_d != 1) begin
      bad++; $display("FAIL stats_last: last=%0d ep=%0d tuples=%0d want 63/3/67",
                      last_ep_steps, ep_count, got_q.size() - b_got);
    end
  endtask
`endif

  initial begin
    bus.upd_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      nt[i]   = '0;
      qmem[i] = '0;
    end
    test_reset();
    test_single_goal();
    test_step_limit();
    test_stall();
    test_abort();
    test_zero_and_busy();
    test_midreset();
    test_random();
`ifdef EPISODE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
